// File: rtl/imm_extender_pkg.sv
// Shared types and parameter sanity helpers for the immediate extender.
package imm_ext_pkg;

    // Extension mode carried alongside each immediate from decode.
    typedef enum logic [1:0] {
        SEXT   = 2'b00,
        ZEXT   = 2'b01,
        BRANCH = 2'b10,
        UPPER  = 2'b11
    } imm_mode_e;

    // Occupancy of the main/skid register pair.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } imm_state_e;

    // True when the width parameters describe a buildable extender.
    function automatic bit widths_legal(input int in_w, input int out_w,
                                        input int shift, input int tag_w);
        return (in_w >= 1) && (in_w < out_w) &&
               (shift >= 0) && (shift < out_w) &&
               (tag_w >= 1);
    endfunction

endpackage

// File: rtl/imm_extender_if.sv
// Handshake bundle between decode, the extender and the ALU operand mux.
interface imm_extender_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 8,
    parameter int TAG_W = 3
);
    import imm_ext_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    imm_mode_e        in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    // Environment side: offers immediates and accepts results.
    modport master (
        output in_valid, in_imm, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    // Extender side.
    modport slave (
        input  in_valid, in_imm, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

endinterface

// File: rtl/imm_extender_core.sv
// Purely combinational immediate extension for all four modes.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_W = 8,
    parameter int SHIFT = 1
) (
    input  logic [IN_W-1:0]  imm,
    input  imm_mode_e        mode,
    output logic [OUT_W-1:0] result
);

    logic [OUT_W-1:0] sext_val;
    logic [OUT_W-1:0] zext_val;
    logic [OUT_W-1:0] branch_val;
    logic [OUT_W-1:0] upper_val;

    assign sext_val   = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    assign zext_val   = {{(OUT_W-IN_W){1'b0}}, imm};
    assign branch_val = sext_val << SHIFT;
    assign upper_val  = {imm, {(OUT_W-IN_W){1'b0}}};

    // Pick the extension matching the requested mode.
    always_comb begin
        result = sext_val;
        case (mode)
            SEXT:    result = sext_val;
            ZEXT:    result = zext_val;
            BRANCH:  result = branch_val;
            UPPER:   result = upper_val;
            default: result = sext_val;
        endcase
    end

endmodule

// File: rtl/imm_extender.sv
// Pipelined immediate extender with a two-entry skid buffer so decode can
// stream one immediate per cycle while the operand mux applies back-pressure.
module imm_extender
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_W = 8,
    parameter int SHIFT = 1,
    parameter int TAG_W = 3
) (
    input logic           clk,
    input logic           reset_n,
    imm_extender_if.slave bus
);

    if (!widths_legal(IN_W, OUT_W, SHIFT, TAG_W)) begin : g_param_check
        $error("imm_extender: illegal IN_W/OUT_W/SHIFT/TAG_W combination");
    end

    imm_state_e       state_q, state_d;
    logic [OUT_W-1:0] main_data_q, main_data_d;
    logic [TAG_W-1:0] main_tag_q, main_tag_d;
    logic [OUT_W-1:0] skid_data_q, skid_data_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

    logic [OUT_W-1:0] ext_data;
    logic             in_ready;
    logic             out_valid;
    logic             in_fire;
    logic             out_fire;

    // Extension happens before storage, so the mode never needs a register.
    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_core (
        .imm    (bus.in_imm),
        .mode   (bus.in_mode),
        .result (ext_data)
    );

    // Both flags come straight from state, so out_ready never reaches in_ready.
    assign in_ready  = reset_n && (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = bus.in_valid && in_ready;
    assign out_fire  = out_valid && bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = main_data_q;
    assign bus.out_tag   = main_tag_q;

    // Occupancy FSM: main always holds the oldest entry, skid the younger one.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_tag_d  = main_tag_q;
        skid_data_d = skid_data_q;
        skid_tag_d  = skid_tag_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_data_d = ext_data;
                    main_tag_d  = bus.in_tag;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_data_d = ext_data;
                    main_tag_d  = bus.in_tag;
                end else if (in_fire) begin
                    skid_data_d = ext_data;
                    skid_tag_d  = bus.in_tag;
                    state_d     = TWO;
                end else if (out_fire) begin
                    state_d     = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    main_data_d = skid_data_q;
                    main_tag_d  = skid_tag_q;
                    state_d     = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Synchronous active-low reset clears state and both storage registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_tag_q  <= '0;
            skid_data_q <= '0;
            skid_tag_q  <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_tag_q  <= main_tag_d;
            skid_data_q <= skid_data_d;
            skid_tag_q  <= skid_tag_d;
        end
    end

endmodule

// File: doc/imm_extender.md
# imm_extender

Parametrised, pipelined immediate-extension unit for the 8-bit MIPS datapath. It converts an IN_W-bit instruction immediate into an OUT_W-bit operand in one of four modes: sign, zero, branch-offset, or upper-load. The unit sits between decode and the ALU operand mux. It uses a valid/ready handshake, and a two-entry skid buffer gives full throughput under back-pressure. A sideband tag (e.g. destination register id) travels with each operand.

## Interface
- IN_W, default 4: immediate width; 1 ≤ IN_W < OUT_W.
- OUT_W, default 8: extended operand width.
- SHIFT, default 1: left-shift amount for branch-offset mode; 0 ≤ SHIFT < OUT_W.
- TAG_W, default 3: sideband tag width, ≥ 1.
- clk, input, 1: the single clock; all state updates on its rising edge.
- reset_n, input, 1: synchronous reset, active-low; sampled on clk rising edge.
- in_valid, input, 1: upstream offers an immediate this cycle.
- in_ready, output, 1: unit accepts this cycle.
- in_imm, input, IN_W: raw immediate.
- in_mode, input, 2: extension mode, encoding in package.
- in_tag, input, TAG_W: sideband, passed through unchanged.
- out_valid, output, 1: result held on out_data/out_tag.
- out_ready, input, 1: downstream accepts this cycle.
- out_data, output, OUT_W: extended operand.
- out_tag, output, TAG_W: tag belonging to out_data.

## Operation
- Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- Modes:
  - SEXT (00): replicate in_imm[IN_W-1] into bits OUT_W-1..IN_W.
  - ZEXT (01): zero-fill bits OUT_W-1..IN_W.
  - BRANCH (10): the SEXT result shifted left by SHIFT, zero-filled low bits, truncated to OUT_W.
  - UPPER (11): in_imm placed at bits OUT_W-1..OUT_W-IN_W, zeros below.
- Extension is computed before registering. Stored entries hold the final OUT_W result plus tag; in_mode is not stored.
- Storage consists of a main register (drives outputs) and a skid register.
- FSM states:
  - EMPTY: main empty.
  - ONE: main full, skid empty.
  - TWO: both full.
- Transitions:
  - EMPTY + in transfer → ONE; the new entry goes into main.
  - ONE + in transfer, no out transfer → TWO; the new entry goes into skid.
  - ONE + out transfer, no in transfer → EMPTY.
  - ONE + both → ONE; main is replaced by the new entry.
  - TWO + out transfer → ONE; skid moves to main. No input is accepted in TWO.
- in_ready is asserted in EMPTY and ONE and deasserted in TWO. It is registered (derived from state), so it has no combinational path from out_ready.
- out_valid is asserted in ONE and TWO.
- Order is strictly FIFO. No entry is dropped or duplicated.
- in_imm, in_mode and in_tag are ignored when no input transfer occurs.

## Timing
- Latency: an entry accepted in cycle N appears on out_data/out_valid in cycle N+1 when the unit was EMPTY. When main was occupied, it appears after all older entries drain.
- Throughput is one transfer per cycle with out_ready held high.
- Reset: on a clk edge with reset_n low:
  - state goes to EMPTY;
  - out_valid = 0, out_data = 0, out_tag = 0;
  - skid contents = 0.
- in_ready is 0 while reset_n is low (gated with reset_n). It is 1 from the first cycle after reset_n rises.
- Reset mid-operation discards both entries with no output transfer. Handshakes in the reset cycle are ignored on both sides.
- Simultaneous in and out transfers in ONE keep one entry in flight, with no bubble.
- out_data and out_tag are stable while out_valid & !out_ready.

## Structure
- Package imm_ext_pkg holds:
  - the mode typedef (2-bit enum SEXT, ZEXT, BRANCH, UPPER);
  - the FSM state typedef (EMPTY, ONE, TWO);
  - the width-legality checks as elaboration-time assertions (IN_W < OUT_W, SHIFT < OUT_W).
- Sub-module imm_ext_core is the purely combinational extender (in_imm, in_mode → OUT_W result). The top level holds the FSM, main/skid registers and handshake logic.

## Test plan
- Defaults, out_ready = 1, in_imm = 4'hA, all four modes back-to-back → out_data = 8'hFA, 8'h0A, 8'hF4, 8'hA0 on consecutive cycles, each one cycle after acceptance, tags preserved.
- in_imm = 4'h5 in SEXT / BRANCH → 8'h05 / 8'h0A. in_imm = 4'h8 in SEXT → 8'hF8.
- out_ready held 0, three offers (tags 1, 2, 3) → first two accepted, in_ready drops after second, third waits. Release out_ready → outputs tags 1, 2, 3 in order with no gaps.
- Random in_valid/out_ready toggling over 1000 transfers → scoreboard matches reference model, no loss, no reorder, outputs stable while stalled.
- reset_n low for one cycle while in TWO → next cycle out_valid = 0, out_data = 0, in_ready = 0; after release in_ready = 1 and the held entries never appear.
- Parameter sweep IN_W = 6, OUT_W = 16, SHIFT = 2, in_imm = 6'h21 BRANCH → 16'hFF84.
